// File: rtl/serdes_startup_ctrl_if.sv
// Interface bundling the sequencer's lock/restart inputs and clock-path
// control outputs. The master modport is the sequencer; the slave modport is
// the environment (MMCM, BUFGCE_DIV, OSERDESE3 and data path).
interface serdes_startup_ctrl_if;
  logic       mmcm_locked;
  logic       restart;
  logic       div_clr;
  logic       div_ce;
  logic       serdes_rst;
  logic       data_en;
  logic       busy;
  logic       err;
  logic [2:0] state_o;

  modport master (
    input  mmcm_locked, restart,
    output div_clr, div_ce, serdes_rst, data_en, busy, err, state_o
  );

  modport slave (
    output mmcm_locked, restart,
    input  div_clr, div_ce, serdes_rst, data_en, busy, err, state_o
  );
endinterface

// File: rtl/serdes_startup_ctrl.sv
// Power-up / recovery sequencer for the DAC serializer clocking path.
// Waits for a stable MMCM lock, clears then enables BUFGCE_DIV, holds the
// OSERDESE3 reset and finally releases the parallel data path.
// Optional feature macro: SERDES_TIMEOUT_EN adds a lock-wait timeout that
// parks the sequencer in ERR until restart; without it err is tied low.
module serdes_startup_ctrl #(
  parameter int LOCK_WAIT  = 64,
  parameter int CLR_CYC    = 8,
  parameter int SETTLE_CYC = 16,
  parameter int RST_CYC    = 32,
  parameter int CNT_W      = 16
`ifdef SERDES_TIMEOUT_EN
  , parameter int TIMEOUT_CYC = 65535
`endif
) (
  input  logic                  clk,
  input  logic                  rst_n,
  serdes_startup_ctrl_if.master io_ctl
);

  typedef enum logic [2:0] {
    S_WAIT_LOCK = 3'd0,
    S_CLR       = 3'd1,
    S_SETTLE    = 3'd2,
    S_SRST      = 3'd3,
    S_RUN       = 3'd4,
    S_ERR       = 3'd5
  } state_t;

  localparam logic [CNT_W-1:0] LOCK_LAST   = CNT_W'(LOCK_WAIT - 1);
  localparam logic [CNT_W-1:0] CLR_LAST    = CNT_W'(CLR_CYC - 1);
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYC - 1);
  localparam logic [CNT_W-1:0] RST_LAST    = CNT_W'(RST_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_MAX     = {CNT_W{1'b1}};

  state_t           r_state, w_state_next;
  logic [CNT_W-1:0] r_cnt, w_cnt_next, w_cnt_inc;
  logic             r_sync1, r_locked_s;
  logic             r_div_clr, r_div_ce, r_serdes_rst, r_data_en, r_busy;
  logic             w_div_clr, w_div_ce, w_serdes_rst, w_data_en, w_busy;
  logic             w_seq_state;

  assign w_cnt_inc   = (r_cnt == CNT_MAX) ? r_cnt : r_cnt + 1'b1;
  assign w_seq_state = (r_state == S_CLR) || (r_state == S_SETTLE) ||
                       (r_state == S_SRST) || (r_state == S_RUN);

`ifdef SERDES_TIMEOUT_EN
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYC - 1);
  logic [CNT_W-1:0] r_tmo, w_tmo_next, w_tmo_inc;
  logic             r_err;
  assign w_tmo_inc = (r_tmo == CNT_MAX) ? r_tmo : r_tmo + 1'b1;
`endif

  // Two-flop synchroniser for the asynchronous MMCM LOCKED pin
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1    <= 1'b0;
      r_locked_s <= 1'b0;
    end else begin
      r_sync1    <= io_ctl.mmcm_locked;
      r_locked_s <= r_sync1;
    end
  end

  // Next state and counter; lock loss overrides restart, which overrides the count
  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = w_cnt_inc;
`ifdef SERDES_TIMEOUT_EN
    w_tmo_next   = '0;
`endif
    unique case (r_state)
      S_WAIT_LOCK: begin
        if (!r_locked_s) begin
          w_cnt_next = '0;
        end else if (r_cnt == LOCK_LAST) begin
          w_state_next = S_CLR;
          w_cnt_next   = '0;
        end
`ifdef SERDES_TIMEOUT_EN
        if (w_state_next == S_WAIT_LOCK) begin
          if (r_tmo == TMO_LAST) begin
            w_state_next = S_ERR;
            w_cnt_next   = '0;
          end else begin
            w_tmo_next = w_tmo_inc;
          end
        end
`endif
      end
      S_CLR: begin
        if (r_cnt == CLR_LAST) begin
          w_state_next = S_SETTLE;
          w_cnt_next   = '0;
        end
      end
      S_SETTLE: begin
        if (r_cnt == SETTLE_LAST) begin
          w_state_next = S_SRST;
          w_cnt_next   = '0;
        end
      end
      S_SRST: begin
        if (r_cnt == RST_LAST) begin
          w_state_next = S_RUN;
          w_cnt_next   = '0;
        end
      end
      S_RUN: begin
        w_cnt_next = '0;
      end
      S_ERR: begin
        w_cnt_next = '0;
        if (io_ctl.restart) w_state_next = S_WAIT_LOCK;
      end
      default: begin
        w_state_next = S_WAIT_LOCK;
        w_cnt_next   = '0;
      end
    endcase
    if (w_seq_state && r_locked_s && io_ctl.restart) begin
      w_state_next = S_CLR;
      w_cnt_next   = '0;
    end
    if (w_seq_state && !r_locked_s) begin
      w_state_next = S_WAIT_LOCK;
      w_cnt_next   = '0;
    end
  end

  // Moore output decode of the upcoming state so outputs move with the state
  always_comb begin
    w_div_clr    = 1'b1;
    w_div_ce     = 1'b0;
    w_serdes_rst = 1'b1;
    w_data_en    = 1'b0;
    w_busy       = 1'b1;
    unique case (w_state_next)
      S_SETTLE, S_SRST: begin
        w_div_clr = 1'b0;
        w_div_ce  = 1'b1;
      end
      S_RUN: begin
        w_div_clr    = 1'b0;
        w_div_ce     = 1'b1;
        w_serdes_rst = 1'b0;
        w_data_en    = 1'b1;
        w_busy       = 1'b0;
      end
      S_ERR: begin
        w_busy = 1'b0;
      end
      default: begin
      end
    endcase
  end

  // State, counter and registered output flops
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_WAIT_LOCK;
      r_cnt        <= '0;
      r_div_clr    <= 1'b1;
      r_div_ce     <= 1'b0;
      r_serdes_rst <= 1'b1;
      r_data_en    <= 1'b0;
      r_busy       <= 1'b1;
    end else begin
      r_state      <= w_state_next;
      r_cnt        <= w_cnt_next;
      r_div_clr    <= w_div_clr;
      r_div_ce     <= w_div_ce;
      r_serdes_rst <= w_serdes_rst;
      r_data_en    <= w_data_en;
      r_busy       <= w_busy;
    end
  end

`ifdef SERDES_TIMEOUT_EN
  // Lock-wait timeout counter and the sticky error flag it drives
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tmo <= '0;
      r_err <= 1'b0;
    end else begin
      r_tmo <= w_tmo_next;
      r_err <= (w_state_next == S_ERR);
    end
  end
  assign io_ctl.err = r_err;
`else
  assign io_ctl.err = 1'b0;
`endif

  assign io_ctl.div_clr    = r_div_clr;
  assign io_ctl.div_ce     = r_div_ce;
  assign io_ctl.serdes_rst = r_serdes_rst;
  assign io_ctl.data_en    = r_data_en;
  assign io_ctl.busy       = r_busy;
  assign io_ctl.state_o    = r_state;

endmodule

// File: tb/tb_serdes_startup_ctrl.sv
// Self-checking bench for serdes_startup_ctrl: a table of stimulus/expect
// records plus hand-written sequences for glitch, collision, async reset and
// (with SERDES_TIMEOUT_EN) lock timeout. Expectations go through a queue.
module tb_serdes_startup_ctrl;

  // Expected outputs packed as {div_clr, div_ce, serdes_rst, data_en, busy, err}
  localparam logic [5:0] O_WL  = 6'b101010;
  localparam logic [5:0] O_CLR = 6'b101010;
  localparam logic [5:0] O_SET = 6'b011010;
  localparam logic [5:0] O_RUN = 6'b010100;
  localparam logic [5:0] O_ERR = 6'b101001;
  localparam logic [2:0] ST_WL = 3'd0, ST_CLR = 3'd1, ST_SET = 3'd2;
  localparam logic [2:0] ST_SRST = 3'd3, ST_RUN = 3'd4, ST_ERR = 3'd5;

  typedef struct {
    string      name;
    logic       locked;
    logic       restart;
    int         waitCyc;
    logic [2:0] expState;
    logic [5:0] expOut;
  } vec_t;

  typedef struct {
    string      name;
    logic [2:0] st;
    logic [5:0] out;
  } exp_t;

  logic  clk = 1'b0;
  logic  rst_n;
  int    checks = 0;
  int    errors = 0;
  vec_t  vecs[$];
  exp_t  scoreQ[$];

  serdes_startup_ctrl_if bus();

`ifdef SERDES_TIMEOUT_EN
  serdes_startup_ctrl #(.TIMEOUT_CYC(1000)) dut (
    .clk(clk), .rst_n(rst_n), .io_ctl(bus)
  );
`else
  serdes_startup_ctrl dut (
    .clk(clk), .rst_n(rst_n), .io_ctl(bus)
  );
`endif

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit expired");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic addVec(input string n, input logic l, input logic r,
                        input int w, input logic [2:0] s, input logic [5:0] o);
    vec_t v;
    v.name = n; v.locked = l; v.restart = r; v.waitCyc = w;
    v.expState = s; v.expOut = o;
    vecs.push_back(v);
  endtask

  task automatic checkOutput();
    exp_t       e;
    logic [5:0] act;
    checks++;
    if (scoreQ.size() == 0) begin
      errors++;
      $display("[TB] FAIL scoreboard: no expected entry queued");
    end else begin
      e   = scoreQ.pop_front();
      act = {bus.div_clr, bus.div_ce, bus.serdes_rst, bus.data_en, bus.busy, bus.err};
      if (bus.state_o !== e.st || act !== e.out) begin
        errors++;
        $display("[TB] FAIL %s: got state=%0d out=%b, expected state=%0d out=%b",
                 e.name, bus.state_o, act, e.st, e.out);
      end
    end
  endtask

  task automatic expectNow(input string n, input logic [2:0] s, input logic [5:0] o);
    exp_t e;
    e.name = n; e.st = s; e.out = o;
    scoreQ.push_back(e);
    checkOutput();
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      bus.restart = 1'b0;
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    exp_t e;
    bus.mmcm_locked = v.locked;
    bus.restart     = v.restart;
    e.name = v.name; e.st = v.expState; e.out = v.expOut;
    scoreQ.push_back(e);
    tick(v.waitCyc);
    checkOutput();
  endtask

  task automatic resetDut();
    rst_n           = 1'b0;
    bus.mmcm_locked = 1'b0;
    bus.restart     = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    // Cycle-by-cycle milestones of the nominal sequence, restart and relock
    addVec("reset_state",        1'b1, 1'b0,   0, ST_WL,   O_WL);
    addVec("wait_lock_edge65",   1'b1, 1'b0,  65, ST_WL,   O_WL);
    addVec("clr_edge66",         1'b1, 1'b0,   1, ST_CLR,  O_CLR);
    addVec("clr_edge73",         1'b1, 1'b0,   7, ST_CLR,  O_CLR);
    addVec("settle_edge74",      1'b1, 1'b0,   1, ST_SET,  O_SET);
    addVec("settle_edge89",      1'b1, 1'b0,  15, ST_SET,  O_SET);
    addVec("srst_edge90",        1'b1, 1'b0,   1, ST_SRST, O_SET);
    addVec("srst_edge121",       1'b1, 1'b0,  31, ST_SRST, O_SET);
    addVec("run_edge122",        1'b1, 1'b0,   1, ST_RUN,  O_RUN);
    addVec("restart_to_clr",     1'b1, 1'b1,   1, ST_CLR,  O_CLR);
    addVec("restart_srst_55",    1'b1, 1'b0,  55, ST_SRST, O_SET);
    addVec("restart_run_56",     1'b1, 1'b0,   1, ST_RUN,  O_RUN);
    addVec("lockloss_in_sync",   1'b0, 1'b0,   2, ST_RUN,  O_RUN);
    addVec("lockloss_wait_lock", 1'b0, 1'b0,   1, ST_WL,   O_WL);
    addVec("relock_waiting",     1'b1, 1'b0,  10, ST_WL,   O_WL);
    addVec("restart_ignored_wl", 1'b1, 1'b1,   1, ST_WL,   O_WL);
    addVec("relock_srst_121",    1'b1, 1'b0, 110, ST_SRST, O_SET);
    addVec("relock_run_122",     1'b1, 1'b0,   1, ST_RUN,  O_RUN);

    resetDut();
    for (int i = 0; i < vecs.size(); i++) applyStimulus(vecs[i]);

    // restart with lock already lost while in SETTLE: lock loss must win
    bus.restart = 1'b1;
    tick(1);
    expectNow("collide_clr", ST_CLR, O_CLR);
    tick(8);
    expectNow("collide_settle", ST_SET, O_SET);
    bus.mmcm_locked = 1'b0;
    tick(2);
    expectNow("collide_settle_held", ST_SET, O_SET);
    bus.restart = 1'b1;
    tick(1);
    expectNow("collide_lockloss_wins", ST_WL, O_WL);

    // One-cycle lock glitch in cycle 40 delays data_en by 41 cycles
    resetDut();
    bus.mmcm_locked = 1'b1;
    tick(40);
    bus.mmcm_locked = 1'b0;
    tick(1);
    bus.mmcm_locked = 1'b1;
    tick(121);
    expectNow("glitch_srst_162", ST_SRST, O_SET);
    tick(1);
    expectNow("glitch_run_163", ST_RUN, O_RUN);

    // Asynchronous reset in RUN restores safe outputs without a clock edge
    #2;
    rst_n = 1'b0;
    #1;
    expectNow("async_reset_in_run", ST_WL, O_WL);
    rst_n = 1'b1;

`ifdef SERDES_TIMEOUT_EN
    // Lock never arrives: ERR at edge 1000, lock ignored, restart clears it
    resetDut();
    tick(999);
    expectNow("timeout_edge999", ST_WL, O_WL);
    tick(1);
    expectNow("timeout_err_1000", ST_ERR, O_ERR);
    bus.mmcm_locked = 1'b1;
    tick(6);
    expectNow("err_ignores_lock", ST_ERR, O_ERR);
    bus.restart = 1'b1;
    tick(1);
    expectNow("err_restart_wl", ST_WL, O_WL);
`else
    // Without the timeout feature a long lockless wait never raises err
    resetDut();
    tick(1500);
    expectNow("no_timeout_wait", ST_WL, O_WL);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
